// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI slave controller and its shift registers.
package spi_pkg;
  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam logic RW_READ = 1'b1;

  typedef enum logic [2:0] {
    IDLE, GET_CMD, READ_LOAD, READ_SEND, WRITE_GET, WRITE_COMMIT, DONE
  } state_t;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/spi_shift_reg.sv
// MSB-first shift register with parallel load; exposes its top TAP_W bits.
module spi_shift_reg #(
  parameter int W     = 8,
  parameter int TAP_W = W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [W-1:0]     load_data,
  input  logic             shift_en,
  input  logic             serial_in,
  output logic [TAP_W-1:0] tap
);
  logic [W-1:0] q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      q <= '0;
    else if (load)     q <= load_data;
    else if (shift_en) q <= {q[W-2:0], serial_in};
  end

  assign tap = q[W-1 -: TAP_W];
endmodule

// File: rtl/spi_slave_controller.sv
// SPI slave engine: 7-bit address + R/W command, then one data byte written to
// or read from the memory port. Runs entirely on conditioned, clk-domain inputs.
module spi_slave_controller
  import spi_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_W_DEF,
  parameter int DATA_WIDTH = DATA_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cs_cond,
  input  logic                  sclk_posedge,
  input  logic                  sclk_negedge,
  input  logic                  mosi_cond,
  output logic                  miso_out,
  output logic                  miso_oe,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_wr_en,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);
  // The final command/data bit is taken straight from mosi_cond, so the input
  // register only has to hold the bits that precede it.
  localparam int SR_W  = max_int(ADDR_WIDTH, DATA_WIDTH - 1);
  localparam int CNT_W = $clog2(max_int(ADDR_WIDTH + 1, DATA_WIDTH)) + 1;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [SR_W-1:0]  in_q;
  logic             in_shift, rd_load, rd_shift;

  assign in_shift = !cs_cond && sclk_posedge && (state == GET_CMD || state == WRITE_GET);
  assign rd_load  = !cs_cond && state == READ_LOAD && cnt == CNT_W'(1);
  assign rd_shift = !cs_cond && sclk_negedge && state == READ_SEND;

  spi_shift_reg #(.W(SR_W), .TAP_W(SR_W)) u_in_sr (
    .clk(clk), .reset_n(reset_n), .load(1'b0), .load_data('0),
    .shift_en(in_shift), .serial_in(mosi_cond), .tap(in_q)
  );

  spi_shift_reg #(.W(DATA_WIDTH), .TAP_W(1)) u_rd_sr (
    .clk(clk), .reset_n(reset_n), .load(rd_load), .load_data(mem_rd_data),
    .shift_en(rd_shift), .serial_in(1'b0), .tap(miso_out)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      cnt         <= '0;
      miso_oe     <= 1'b0;
      mem_addr    <= '0;
      mem_wr_en   <= 1'b0;
      mem_wr_data <= '0;
    end else begin
      mem_wr_en <= 1'b0;
      // CS release beats any edge pulse in the same cycle
      if (state != IDLE && cs_cond) begin
        state   <= IDLE;
        cnt     <= '0;
        miso_oe <= 1'b0;
      end else begin
        case (state)
          IDLE: if (!cs_cond) begin
            state <= GET_CMD;
            cnt   <= '0;
          end
          GET_CMD: if (sclk_posedge) begin
            if (cnt == CNT_W'(ADDR_WIDTH)) begin
              mem_addr <= in_q[ADDR_WIDTH-1:0];
              cnt      <= '0;
              state    <= (mosi_cond == RW_READ) ? READ_LOAD : WRITE_GET;
            end else cnt <= cnt + 1'b1;
          end
          // cycle 0: address settles, cycle 1: read data valid and loaded
          READ_LOAD: if (cnt == CNT_W'(1)) begin
            miso_oe <= 1'b1;
            cnt     <= '0;
            state   <= READ_SEND;
          end else cnt <= cnt + 1'b1;
          READ_SEND: if (sclk_negedge) begin
            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
              miso_oe <= 1'b0;
              cnt     <= '0;
              state   <= DONE;
            end else cnt <= cnt + 1'b1;
          end
          // Strobe is registered on the last data edge so it is visible during WRITE_COMMIT.
          WRITE_GET: if (sclk_posedge) begin
            if (cnt == CNT_W'(DATA_WIDTH - 1)) begin
              mem_wr_data <= {in_q[DATA_WIDTH-2:0], mosi_cond};
              mem_wr_en   <= 1'b1;
              cnt         <= '0;
              state       <= WRITE_COMMIT;
            end else cnt <= cnt + 1'b1;
          end
          WRITE_COMMIT: state <= DONE;
          DONE: state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
